// File: rtl/clk_div.sv
`timescale 1ns / 1ps
// clk_div: divides the system clock into 1 ms / 10 ms / 100 ms / 1 s
// single-cycle enables; downstream logic stays on I_CLK.
module clk_div #(
    parameter int DIV_1MS = 16000,
    parameter int DIV_DEC = 10
) (
    input  logic I_CLK,
    input  logic I_RST,
    output logic O_EN_1MS,
    output logic O_EN_10MS,
    output logic O_EN_100MS,
    output logic O_EN_1S
);

    localparam int W1 = (DIV_1MS > 1) ? $clog2(DIV_1MS) : 1;
    localparam int WD = (DIV_DEC > 1) ? $clog2(DIV_DEC) : 1;
    localparam logic [W1-1:0] LAST_1MS = W1'(DIV_1MS - 1);
    localparam logic [WD-1:0] LAST_DEC = WD'(DIV_DEC - 1);
    localparam logic [W1-1:0] ONE_1MS  = W1'(1);
    localparam logic [WD-1:0] ONE_DEC  = WD'(1);

    logic [W1-1:0] cnt_1ms;
    logic [WD-1:0] cnt_10;
    logic [WD-1:0] cnt_100;
    logic [WD-1:0] cnt_1000;

    logic t0;
    logic t1;
    logic t2;
    logic t3;

    // Each terminal tick nests inside the finer one, so stages never skew.
    assign t0 = (cnt_1ms == LAST_1MS);
    assign t1 = t0 && (cnt_10 == LAST_DEC);
    assign t2 = t1 && (cnt_100 == LAST_DEC);
    assign t3 = t2 && (cnt_1000 == LAST_DEC);

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            cnt_1ms    <= '0;
            cnt_10     <= '0;
            cnt_100    <= '0;
            cnt_1000   <= '0;
            O_EN_1MS   <= 1'b0;
            O_EN_10MS  <= 1'b0;
            O_EN_100MS <= 1'b0;
            O_EN_1S    <= 1'b0;
        end else begin
            cnt_1ms <= t0 ? '0 : cnt_1ms + ONE_1MS;
            if (t0) begin
                cnt_10 <= t1 ? '0 : cnt_10 + ONE_DEC;
            end
            if (t1) begin
                cnt_100 <= t2 ? '0 : cnt_100 + ONE_DEC;
            end
            if (t2) begin
                cnt_1000 <= t3 ? '0 : cnt_1000 + ONE_DEC;
            end
            O_EN_1MS   <= t0;
            O_EN_10MS  <= t1;
            O_EN_100MS <= t2;
            O_EN_1S    <= t3;
        end
    end

endmodule

// File: tb/tb_clk_div.sv
`timescale 1ns / 1ps
// tb_clk_div: randomized reset/run stimulus checked against an
// edge-count reference model (pulse when count is a multiple of period).
module tb_clk_div;

    localparam int D = 4;
    localparam int R = 3;
    localparam int BIG = 16000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_big = 1'b1;
    logic [3:0] en;
    logic [3:0] en_big;
    logic big_done = 1'b0;

    int checks = 0;
    int failures = 0;
    longint k = 0;
    int cnt [4];

    clk_div #(.DIV_1MS(D), .DIV_DEC(R)) u_dut (
        .I_CLK(clk),
        .I_RST(rst),
        .O_EN_1MS(en[0]),
        .O_EN_10MS(en[1]),
        .O_EN_100MS(en[2]),
        .O_EN_1S(en[3])
    );

    clk_div u_big (
        .I_CLK(clk),
        .I_RST(rst_big),
        .O_EN_1MS(en_big[0]),
        .O_EN_10MS(en_big[1]),
        .O_EN_100MS(en_big[2]),
        .O_EN_1S(en_big[3])
    );

    always #31.25 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stage i pulses after edge n when n is a multiple of d*r^i.
    function automatic logic [3:0] model(input longint n, input longint d,
                                         input longint r);
        logic [3:0] m;
        longint p;
        m = '0;
        p = d;
        for (int i = 0; i < 4; i++) begin
            m[i] = (n > 0) && (n % p == 0);
            p = p * r;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) k++;
        #1;
        chk("en", {28'd0, en}, {28'd0, model(k, D, R)});
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        k = 0;
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        k = 0;
        #1;
        chk("async_drop", {28'd0, en}, 32'd0);
    endtask

    initial begin
        longint kb = 0;
        #100;
        rst_big = 1'b0;
        repeat (3 * BIG + 1) begin
            @(posedge clk);
            kb++;
            #1;
            chk("big", {28'd0, en_big},
                {31'd0, (kb % BIG == 0) ? 1'b1 : 1'b0});
        end
        big_done = 1'b1;
    end

    initial begin
        int n;
        repeat (10) tick();
        chk("rst_cnt", {31'd0, u_dut.cnt_1ms == '0}, 32'd1);

        release_rst();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        repeat (1000) begin
            tick();
            for (int i = 0; i < 4; i++) cnt[i] += int'(en[i]);
        end
        chk("n_1ms", cnt[0], 250);
        chk("n_10ms", cnt[1], 83);
        chk("n_100ms", cnt[2], 27);
        chk("n_1s", cnt[3], 9);

        #10;
        assert_rst();
        repeat (3) tick();
        release_rst();
        repeat (108) tick();
        chk("wrap_all", {28'd0, en}, 32'hf);

        #10;
        assert_rst();
        repeat (2) tick();
        release_rst();
        repeat (30) tick();
        #10;
        assert_rst();
        tick();
        release_rst();
        repeat (12) tick();
        chk("10ms_after_rst", {31'd0, en[1]}, 32'd1);

        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(150, 4);
            repeat (n) tick();
            for (int j = 0; j < 2 * D && !en[0]; j++) tick();
            chk("pulse_seen", {31'd0, en[0]}, 32'd1);
            #($urandom_range(25, 2));
            assert_rst();
            repeat ($urandom_range(4, 1)) tick();
            release_rst();
        end
        repeat (120) tick();

        for (int i = 0; i < 60000 && !big_done; i++) @(posedge clk);
        chk("big_done", {31'd0, big_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
